// File: rtl/video_object_tracker_pkg.sv
// Shared timing defaults, colour target and types for the video object tracker.
package video_object_tracker_pkg;

   localparam int unsigned H_DISPLAY = 256;
   localparam int unsigned H_BACK    = 23;
   localparam int unsigned H_TOTAL   = 309;
   localparam int unsigned V_DISPLAY = 240;
   localparam int unsigned V_TOP     = 5;
   localparam int unsigned V_TOTAL   = 262;
   localparam int unsigned V_SYNC    = 3;

   localparam logic [2:0] COLOR_MASK  = 3'b111;
   localparam logic [2:0] COLOR_MATCH = 3'b111;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_TRACK    = 1'b1
   } trk_state_e;

   typedef struct packed {
      logic [8:0] min_x;
      logic [8:0] max_x;
      logic [8:0] min_y;
      logic [8:0] max_y;
   } bbox_t;

endpackage

// File: rtl/video_object_tracker_beam_recovery.sv
// Recovers beam position from hsync/vsync edges; all outputs are aligned with rgb_q.
module video_object_tracker_beam_recovery #(
   parameter int unsigned H_DISPLAY = 256,
   parameter int unsigned H_BACK    = 23,
   parameter int unsigned H_TOTAL   = 309,
   parameter int unsigned V_DISPLAY = 240,
   parameter int unsigned V_TOP     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [2:0] rgb,
   output logic [2:0] rgb_q,
   output logic       vs_fall,
   output logic       vs_rise,
   output logic [8:0] line_cnt,
   output logic [8:0] x_c,
   output logic [8:0] y_c,
   output logic       active_c,
   output logic       timeout_c
);

   localparam logic [9:0] X_SAT = 10'(2 * H_TOTAL);

   logic       hs_q;
   logic       vs_q;
   logic [9:0] x_raw;
   logic       hs_fall_c;
   logic       vs_fall_c;
   logic       vs_rise_c;

   assign hs_fall_c = hs_q & ~hsync;
   assign vs_fall_c = vs_q & ~vsync;
   assign vs_rise_c = ~vs_q & vsync;

   // vsync clear wins over a coincident hsync fall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         rgb_q    <= '0;
         vs_fall  <= 1'b0;
         vs_rise  <= 1'b0;
         x_raw    <= '0;
         line_cnt <= '0;
      end else begin
         hs_q    <= hsync;
         vs_q    <= vsync;
         rgb_q   <= rgb;
         vs_fall <= vs_fall_c;
         vs_rise <= vs_rise_c;
         if (hs_fall_c)
            x_raw <= '0;
         else if (x_raw != X_SAT)
            x_raw <= x_raw + 10'd1;
         if (vs_fall_c)
            line_cnt <= '0;
         else if (hs_fall_c)
            line_cnt <= line_cnt + 9'd1;
      end
   end

   assign x_c       = 9'(x_raw - 10'(H_BACK));
   assign y_c       = line_cnt - 9'(V_TOP);
   assign active_c  = (x_raw >= 10'(H_BACK)) && (x_raw < 10'(H_BACK + H_DISPLAY)) &&
                      (line_cnt >= 9'(V_TOP)) && (line_cnt < 9'(V_TOP + V_DISPLAY));
   assign timeout_c = (x_raw == X_SAT);

endmodule

// File: rtl/video_object_tracker.sv
// Per-frame bounding box of target-coloured pixels recovered from a sync/rgb stream.
// Optional frame-to-frame motion output enabled by VIDEO_OBJECT_TRACKER_VELOCITY_EN.
module video_object_tracker
   import video_object_tracker_pkg::*;
#(
   parameter int unsigned H_DISPLAY   = video_object_tracker_pkg::H_DISPLAY,
   parameter int unsigned H_BACK      = video_object_tracker_pkg::H_BACK,
   parameter int unsigned H_TOTAL     = video_object_tracker_pkg::H_TOTAL,
   parameter int unsigned V_DISPLAY   = video_object_tracker_pkg::V_DISPLAY,
   parameter int unsigned V_TOP       = video_object_tracker_pkg::V_TOP,
   parameter int unsigned V_TOTAL     = video_object_tracker_pkg::V_TOTAL,
   parameter int unsigned V_SYNC      = video_object_tracker_pkg::V_SYNC,
   parameter logic [2:0]  COLOR_MASK  = video_object_tracker_pkg::COLOR_MASK,
   parameter logic [2:0]  COLOR_MATCH = video_object_tracker_pkg::COLOR_MATCH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [2:0] rgb,
   output logic       locked,
   output logic       frame_strobe,
   output logic       obj_found,
   output logic [8:0] obj_hpos,
   output logic [8:0] obj_vpos,
   output logic [8:0] obj_width,
   output logic [8:0] obj_height,
   output logic [8:0] obj_dx,
   output logic [8:0] obj_dy
);

   logic [2:0] rgb_q;
   logic       vs_fall;
   logic       vs_rise;
   logic [8:0] line_cnt;
   logic [8:0] x_c;
   logic [8:0] y_c;
   logic       active_c;
   logic       timeout_c;

   video_object_tracker_beam_recovery #(
      .H_DISPLAY (H_DISPLAY),
      .H_BACK    (H_BACK),
      .H_TOTAL   (H_TOTAL),
      .V_DISPLAY (V_DISPLAY),
      .V_TOP     (V_TOP)
   ) u_beam (
      .clk       (clk),
      .reset     (reset),
      .hsync     (hsync),
      .vsync     (vsync),
      .rgb       (rgb),
      .rgb_q     (rgb_q),
      .vs_fall   (vs_fall),
      .vs_rise   (vs_rise),
      .line_cnt  (line_cnt),
      .x_c       (x_c),
      .y_c       (y_c),
      .active_c  (active_c),
      .timeout_c (timeout_c)
   );

   trk_state_e state;
   trk_state_e state_nx;
   logic       acc_en_c;
   logic       frame_end_c;
   logic       abort_c;
   logic       frame_ok_c;
   logic       hit;
   bbox_t      acc;

   assign frame_ok_c = (line_cnt == 9'(V_TOTAL - V_SYNC));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_UNLOCKED;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_UNLOCKED: if (vs_fall)   state_nx = ST_TRACK;
         ST_TRACK:    if (timeout_c) state_nx = ST_UNLOCKED;
         default:                    state_nx = ST_UNLOCKED;
      endcase
   end

   always_comb begin
      acc_en_c    = 1'b0;
      frame_end_c = 1'b0;
      abort_c     = 1'b0;
      if (state == ST_TRACK) begin
         if (timeout_c)
            abort_c = 1'b1;
         else if (vs_rise)
            frame_end_c = 1'b1;
         else
            acc_en_c = active_c && ((rgb_q & COLOR_MASK) == COLOR_MATCH);
      end
   end

   // Accumulators and per-frame result registers; results only move on a good frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit          <= 1'b0;
         acc          <= '0;
         locked       <= 1'b0;
         frame_strobe <= 1'b0;
         obj_found    <= 1'b0;
         obj_hpos     <= '0;
         obj_vpos     <= '0;
         obj_width    <= '0;
         obj_height   <= '0;
      end else begin
         frame_strobe <= 1'b0;
         if (abort_c) begin
            locked <= 1'b0;
            hit    <= 1'b0;
            acc    <= '0;
         end else if (frame_end_c) begin
            hit <= 1'b0;
            acc <= '0;
            if (frame_ok_c) begin
               locked       <= 1'b1;
               frame_strobe <= 1'b1;
               obj_found    <= hit;
               if (hit) begin
                  obj_hpos   <= acc.min_x;
                  obj_vpos   <= acc.min_y;
                  obj_width  <= acc.max_x - acc.min_x + 9'd1;
                  obj_height <= acc.max_y - acc.min_y + 9'd1;
               end
            end else begin
               locked <= 1'b0;
            end
         end else if (acc_en_c) begin
            hit       <= 1'b1;
            acc.min_x <= (!hit || x_c < acc.min_x) ? x_c : acc.min_x;
            acc.max_x <= (!hit || x_c > acc.max_x) ? x_c : acc.max_x;
            acc.min_y <= (!hit || y_c < acc.min_y) ? y_c : acc.min_y;
            acc.max_y <= (!hit || y_c > acc.max_y) ? y_c : acc.max_y;
         end
      end
   end

`ifdef VIDEO_OBJECT_TRACKER_VELOCITY_EN
   logic [8:0] prev_hpos;
   logic [8:0] prev_vpos;
   logic       prev_valid;

   // Motion is only meaningful across two consecutive good frames with hits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_hpos  <= '0;
         prev_vpos  <= '0;
         prev_valid <= 1'b0;
         obj_dx     <= '0;
         obj_dy     <= '0;
      end else if (abort_c) begin
         prev_valid <= 1'b0;
      end else if (frame_end_c) begin
         if (frame_ok_c && hit) begin
            obj_dx     <= prev_valid ? acc.min_x - prev_hpos : '0;
            obj_dy     <= prev_valid ? acc.min_y - prev_vpos : '0;
            prev_hpos  <= acc.min_x;
            prev_vpos  <= acc.min_y;
            prev_valid <= 1'b1;
         end else begin
            prev_valid <= 1'b0;
            if (frame_ok_c) begin
               obj_dx <= '0;
               obj_dy <= '0;
            end
         end
      end
   end
`else
   assign obj_dx = '0;
   assign obj_dy = '0;
`endif

endmodule
